// File: rtl/conv_window_scheduler_pkg.sv
// Shared types and constants for the 3x3 convolution window scheduler.
//   sched_state_t : scheduler FSM state encoding
//   PIX_W, KERNEL : pixel width and kernel edge length
//   DEF_*         : default image geometry and MAC pipeline depth
//   clog2_min1    : address width helper that never returns zero
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_COEFF,
      STREAM,
      DRAIN,
      DONE
   } sched_state_t;

   localparam int PIX_W        = 8;
   localparam int KERNEL       = 3;
   localparam int DEF_IMG_W    = 8;
   localparam int DEF_IMG_H    = 8;
   localparam int DEF_PIPE_LAT = 3;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_window_scheduler_raster_counter.sv
// Column/row raster counter used to generate image read coordinates.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force both counters to zero (wins over en)
//   en       : advance one pixel; col wraps COLS-1 -> 0 and bumps row
//   col, row : current coordinate
//   last     : current coordinate is the final pixel (ROWS-1, COLS-1)
module raster_counter #(
   parameter int COLS = 8,
   parameter int ROWS = 8,
   parameter int CW   = 3,
   parameter int RW   = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (en) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences one full-frame 3x3 convolution pass: raster-reads the image
// memory, shifts the line buffer one cycle after each read, flags interior
// windows, tracks them through the MAC pipeline and addresses the result
// memory. A global stall freezes every piece of state.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a pass (only looked at in IDLE)
//   coeff_ready     : filter coefficients are loaded
//   stall           : freeze all progress this cycle
//   rd_en, rd_addr  : image memory read strobe / address (row*IMG_W+col)
//   shift_en        : line buffer shifts in the memory read data
//   win_valid       : this shift completes an interior 3x3 window
//   mac_enable      : clock enable for the MAC pipeline registers
//   out_valid       : MAC result valid
//   data_write      : result memory write strobe
//   out_addr        : result memory write address
//   busy, done      : pass in progress / one-cycle end-of-pass pulse
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | waiting for start
// WAIT_COEFF | start seen, waiting for coefficients; no reads
// STREAM     | issuing raster reads, one per unstalled cycle
// DRAIN      | reads finished; flushing the last shift and MAC pipeline
// DONE       | single-cycle done pulse, then back to IDLE
module conv_window_scheduler
   import conv_pkg::*;
#(
   parameter int IMG_W    = DEF_IMG_W,
   parameter int IMG_H    = DEF_IMG_H,
   parameter int PIPE_LAT = DEF_PIPE_LAT,
   parameter int AW       = clog2_min1(IMG_W * IMG_H),
   parameter int OW       = clog2_min1((IMG_W - 2) * (IMG_H - 2))
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          coeff_ready,
   input  logic          stall,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          shift_en,
   output logic          win_valid,
   output logic          mac_enable,
   output logic          out_valid,
   output logic          data_write,
   output logic [OW-1:0] out_addr,
   output logic          busy,
   output logic          done
);

   localparam int CW = clog2_min1(IMG_W);
   localparam int RW = clog2_min1(IMG_H);
   localparam logic [CW-1:0] COL_MIN = CW'(KERNEL - 1);
   localparam logic [RW-1:0] ROW_MIN = RW'(KERNEL - 1);

   sched_state_t state_q, state_d;

   logic [CW-1:0]       rd_col;
   logic [RW-1:0]       rd_row;
   logic                rd_last;

   logic                pend_q, pend_d;
   logic [CW-1:0]       pend_col_q, pend_col_d;
   logic [RW-1:0]       pend_row_q, pend_row_d;
   logic [PIPE_LAT-1:0] v_q, v_d;
   logic [OW-1:0]       out_addr_q, out_addr_d;

   // Counter is held at the origin outside STREAM so every pass, including
   // one following an aborted pass, begins at pixel 0.
   raster_counter #(
      .COLS (IMG_W),
      .ROWS (IMG_H),
      .CW   (CW),
      .RW   (RW)
   ) u_rd_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q != STREAM),
      .en   (rd_en),
      .col  (rd_col),
      .row  (rd_row),
      .last (rd_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!stall) begin
         case (state_q)
            IDLE:       if (start) state_d = coeff_ready ? STREAM : WAIT_COEFF;
            WAIT_COEFF: if (coeff_ready) state_d = STREAM;
            // Unstalled STREAM always issues a read, so last alone suffices.
            STREAM:     if (rd_last) state_d = DRAIN;
            DRAIN:      if (!pend_q && (v_q == '0)) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      rd_en      = (state_q == STREAM) && !stall;
      mac_enable = ((state_q == STREAM) || (state_q == DRAIN)) && !stall;
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
   end

   // Datapath: a read is followed by its shift on the next unstalled cycle;
   // the read coordinate rides along so the window test can use it.
   always_comb begin
      pend_d     = rd_en | (pend_q & stall);
      pend_col_d = rd_en ? rd_col : pend_col_q;
      pend_row_d = rd_en ? rd_row : pend_row_q;

      v_d = v_q;
      if (!stall) begin
         v_d[0] = win_valid;
         for (int i = 1; i < PIPE_LAT; i++) begin
            v_d[i] = v_q[i-1];
         end
      end

      out_addr_d = out_addr_q;
      if ((state_q != STREAM) && (state_d == STREAM)) begin
         out_addr_d = '0;
      end else if (out_valid && !stall) begin
         // A stalled out_valid repeats the same write; advance only once.
         out_addr_d = out_addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q     <= 1'b0;
         pend_col_q <= '0;
         pend_row_q <= '0;
         v_q        <= '0;
         out_addr_q <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_col_q <= pend_col_d;
         pend_row_q <= pend_row_d;
         v_q        <= v_d;
         out_addr_q <= out_addr_d;
      end
   end

   assign rd_addr    = AW'(rd_row) * AW'(IMG_W) + AW'(rd_col);
   assign shift_en   = pend_q & ~stall;
   assign win_valid  = shift_en && (pend_row_q >= ROW_MIN) && (pend_col_q >= COL_MIN);
   assign out_valid  = v_q[PIPE_LAT-1];
   assign data_write = out_valid;
   assign out_addr   = out_addr_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler at IMG_W=IMG_H=4, PIPE_LAT=3.
// Cycle 0 of each pass is the cycle the start pulse is driven.
module tb_conv_window_scheduler;

   logic       clk = 1'b0;
   logic       rst, start, coeff_ready, stall;
   logic       rd_en, shift_en, win_valid, mac_enable, out_valid, data_write;
   logic       busy, done;
   logic [3:0] rd_addr;
   logic [1:0] out_addr;

   always #5 clk = ~clk;

   conv_window_scheduler #(
      .IMG_W    (4),
      .IMG_H    (4),
      .PIPE_LAT (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .coeff_ready (coeff_ready),
      .stall       (stall),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .shift_en    (shift_en),
      .win_valid   (win_valid),
      .mac_enable  (mac_enable),
      .out_valid   (out_valid),
      .data_write  (data_write),
      .out_addr    (out_addr),
      .busy        (busy),
      .done        (done)
   );

   int checks = 0;
   int errors = 0;
   int rd_q[$];
   int wr_q[$];

   typedef struct {
      int id;
      int coeff_rise;
      int coeff_fall;
      int stall_lo;
      int stall_hi;
      int restart_at;
      int exp_done_cyc;
      int exp_reads;
      int exp_writes;
   } scen_t;

   scen_t scen[5];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input int act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h with nothing expected", nm, act);
   endtask

   // Unstalled reference timeline for one 4x4 pass, indexed by progress k.
   // Packed as {rd_en, shift_en, win_valid, mac_enable, out_valid,
   //            data_write, busy, done}.
   function automatic logic [7:0] exp_vec(input int k, input bit stl);
      logic rd, sh, wv, mac, ov, bz, dn;
      rd  = !stl && (k >= 1) && (k <= 16);
      sh  = !stl && (k >= 2) && (k <= 17);
      wv  = !stl && ((k == 12) || (k == 13) || (k == 16) || (k == 17));
      mac = !stl && (k >= 1) && (k <= 21);
      ov  = (k == 15) || (k == 16) || (k == 19) || (k == 20);
      bz  = (k >= 1) && (k <= 22);
      dn  = (k == 22);
      return {rd, sh, wv, mac, ov, ov, bz, dn};
   endfunction

   function automatic logic [7:0] act_vec();
      return {rd_en, shift_en, win_valid, mac_enable, out_valid, data_write, busy, done};
   endfunction

   task automatic push_pass();
      for (int i = 0; i < 16; i++) rd_q.push_back(i);
      for (int i = 0; i < 4; i++) wr_q.push_back(i);
   endtask

   task automatic score(input string tag);
      if (rd_en) begin
         if (rd_q.size() == 0) fail_now({tag, " rd_extra"}, int'(rd_addr));
         else check({tag, " rd_addr"}, int'(rd_addr), rd_q.pop_front());
      end
      if (data_write && !stall) begin
         if (wr_q.size() == 0) fail_now({tag, " wr_extra"}, int'(out_addr));
         else check({tag, " out_addr"}, int'(out_addr), wr_q.pop_front());
      end
   endtask

   task automatic run_scenario(input scen_t s);
      int n_rd, n_wr, n_done, done_cyc, unst;
      logic [7:0] exp;
      string tag;
      n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1; unst = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         start       = (c == 0) || (c == s.restart_at);
         coeff_ready = (c >= s.coeff_rise) && !((s.coeff_fall >= 0) && (c >= s.coeff_fall));
         stall       = (c >= s.stall_lo) && (c <= s.stall_hi);
         if (c == 0) push_pass();
         @(negedge clk);
         tag = $sformatf("s%0d c%0d", s.id, c);
         if (c == 0) begin
            exp = 8'h00;
         end else if (c <= s.coeff_rise) begin
            exp = 8'b0000_0010;
         end else begin
            exp = exp_vec(unst + 1, stall);
            if (!stall) unst++;
         end
         check({tag, " outputs"}, int'(act_vec()), int'(exp));
         score(tag);
         if (rd_en) n_rd++;
         if (data_write && !stall) n_wr++;
         if (done) begin
            n_done++;
            done_cyc = c;
         end
      end
      tag = $sformatf("s%0d", s.id);
      check({tag, " reads"}, n_rd, s.exp_reads);
      check({tag, " writes"}, n_wr, s.exp_writes);
      check({tag, " done_pulses"}, n_done, 1);
      check({tag, " done_cycle"}, done_cyc, s.exp_done_cyc);
      check({tag, " rd_q_left"}, rd_q.size(), 0);
      check({tag, " wr_q_left"}, wr_q.size(), 0);
      rd_q.delete();
      wr_q.delete();
   endtask

   initial begin
      //                id rise fall  slo shi rst  done rd wr
      scen[0] = '{0, 0, -1, -1, -1, -1, 22, 16, 4};   // basic pass
      scen[1] = '{1, 0, -1,  5,  6, -1, 24, 16, 4};   // stall in cycles 5-6
      scen[2] = '{2, 5, -1, -1, -1, -1, 27, 16, 4};   // coefficients late
      scen[3] = '{3, 0,  8, -1, -1,  5, 22, 16, 4};   // start re-pulse, coeff drop
      scen[4] = '{4, 0, -1, 16, 16, -1, 23, 16, 4};   // stall on the last read

      rst = 1'b1; start = 1'b0; coeff_ready = 1'b0; stall = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset outputs", int'(act_vec()), 0);
      check("reset rd_addr", int'(rd_addr), 0);
      check("reset out_addr", int'(out_addr), 0);

      for (int i = 0; i < 5; i++) run_scenario(scen[i]);

      // Reset in the middle of a pass aborts it with no later activity.
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         start = (c == 0); coeff_ready = 1'b1; stall = 1'b0; rst = (c == 8);
         if (c == 0) push_pass();
         @(negedge clk);
         if (c <= 8) begin
            check($sformatf("abort c%0d outputs", c), int'(act_vec()),
                  int'((c == 0) ? 8'h00 : exp_vec(c, 1'b0)));
            score($sformatf("abort c%0d", c));
         end else begin
            check($sformatf("abort c%0d outputs", c), int'(act_vec()), 0);
            check($sformatf("abort c%0d rd_addr", c), int'(rd_addr), 0);
            check($sformatf("abort c%0d out_addr", c), int'(out_addr), 0);
         end
         if (c == 8) begin
            rd_q.delete();
            wr_q.delete();
         end
      end

      // Reset and start in the same cycle: reset wins.
      @(posedge clk); #1 rst = 1'b1; start = 1'b1;
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_vs_start outputs", int'(act_vec()), 0);

      // A fresh pass after the abort replays the basic timing from pixel 0.
      run_scenario(scen[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
Sequences one full-frame 3x3 convolution pass through the filter pipeline once coefficients are loaded.
- Raster-reads pixels from image memory (1-cycle registered read).
- Drives line-buffer shifts and the MAC pipeline enable.
- Flags valid (interior) windows and generates write address/strobe for the result memory.
- Honours a global stall.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
PIPE_LAT, 3, MAC pipeline latency from win_valid to out_valid (>=1)
AW, $clog2(IMG_W*IMG_H), read address width (derived)
OW, $clog2((IMG_W-2)*(IMG_H-2)), output address width (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a frame pass; sampled only in IDLE
coeff_ready  in  1  filter coefficients loaded by the control module
stall  in  1  freeze all progress this cycle
rd_en  out  1  image memory read strobe
rd_addr  out  AW  image memory read address, row*IMG_W+col
shift_en  out  1  line buffer shifts in current memory read data
win_valid  out  1  current shift completes a full 3x3 window
mac_enable  out  1  clock enable for MAC pipeline registers
out_valid  out  1  MAC result valid (win_valid delayed PIPE_LAT unstalled cycles)
data_write  out  1  result memory write strobe (= out_valid)
out_addr  out  OW  result memory write address
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: all outputs 0. State IDLE. Counters, pend and pipeline valid bits cleared. Reset mid-pass aborts immediately; no writes follow.
- FSM states: IDLE, WAIT_COEFF, STREAM, DRAIN, DONE.
- IDLE, start=1: go to STREAM if coeff_ready=1, else WAIT_COEFF. start in any other state is ignored.
- WAIT_COEFF: hold until coeff_ready=1, then go to STREAM. No reads are issued.
- STREAM:
  - rd_en = ~stall.
  - Each issued read advances col; col wraps IMG_W-1 -> 0 and increments row.
  - The read of (IMG_H-1, IMG_W-1) moves the FSM to DRAIN.
  - coeff_ready changes after leaving WAIT_COEFF are ignored.
- Read/shift alignment:
  - pend_next = rd_en | (pend & stall).
  - shift_en = pend & ~stall.
  - Memory output is assumed held while rd_en=0.
  - The (row,col) of each read is carried with pend.
- win_valid = shift_en & shifted row>=2 & shifted col>=2. Border pixels never produce a window.
- Output pipeline:
  - PIPE_LAT-stage valid shift register fed by win_valid.
  - Advances only when ~stall; out_valid = last stage.
  - mac_enable = ~stall & (STREAM | DRAIN).
- out_addr:
  - Starts at 0.
  - Increments after each out_valid; last value (IMG_W-2)*(IMG_H-2)-1.
  - Cleared when entering STREAM.
- DRAIN: when pend=0 and all pipeline valid bits are 0, go to DONE. Reads are never issued in DRAIN.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls with done.
- Simultaneous events:
  - stall has priority over everything except rst.
  - A stall in the same cycle as the last read suppresses that read, and the FSM stays in STREAM.
  - rst beats start.

Decomposition:
- Package conv_pkg:
  - state enum sched_state_t {IDLE, WAIT_COEFF, STREAM, DRAIN, DONE}
  - PIX_W=8, KERNEL=3, default IMG_W/IMG_H constants
- One natural sub-module: raster_counter (col/row counter with enable, wrap, and last-pixel flag). Instantiate it for read coordinates.
- Pend coordinate tracking and the valid pipeline stay inline.

Test Plan:
All scenarios use IMG_W=IMG_H=4, PIPE_LAT=3; cycle 0 = start pulse.
1. Basic pass, coeff_ready=1, no stall -> rd_en cycles 1..16 with rd_addr 0..15; shift_en cycles 2..17; win_valid cycles 12,13,16,17; out_valid cycles 15,16,19,20 with out_addr 0,1,2,3; done=1 only in cycle 22; busy 1 for cycles 1..22.
2. stall=1 in cycles 5-6 -> rd_addr 4 issued at cycle 7 instead of 5; shift of pixel 3 at cycle 7; mac_enable=0 in cycles 5-6; all later events +2; done at cycle 24.
3. start with coeff_ready=0, raised at cycle 5 -> WAIT_COEFF with busy=1 and rd_en=0 through cycle 5; rd_addr 0 at cycle 6.
4. rst=1 at cycle 8 -> from cycle 9: all outputs 0, busy=0, no out_valid. A new start then replays scenario 1 timing from rd_addr 0.
5. start re-pulsed at cycle 5 during STREAM -> ignored; exactly 16 reads and 4 writes; single done pulse.
6. stall=1 during cycle 16 (last read) -> rd_addr 15 issued at cycle 17; DRAIN entered cycle 18; out_addr still ends at 3.
